pc_select_reg: RTL and testbench



---
 rtl/pc_select_reg.sv | 129 ++++++++++++
 tb/tb_pc_select_reg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_select_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_select_reg
// Purpose  : NUM_SRC:1 next-PC source select feeding a PC register with
//            unconditional and branch-conditional write strobes.
//            Optional macro PC_ALIGN_CHECK_EN enables the two-cycle
//            misaligned-target trap (EPC save + fixed vector redirect).
// Revision : 1.0 - initial release
// ============================================================================
module pc_select_reg #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_SRC     = 4,
  parameter int               SEL_W       = $clog2(NUM_SRC),
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h0000_00FC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         selector,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         next_pc,
  output logic [WIDTH-1:0]         epc_out,
  output logic [WIDTH-1:0]         bad_addr,
  output logic                     trap,
  output logic                     busy
);

  logic [WIDTH-1:0] raw_pc;
  logic             we;
  logic [WIDTH-1:0] pc_d, pc_q;

  // Out-of-range selector values match no source and fall back to source 0.
  always_comb begin
    raw_pc = data_in[0 +: WIDTH];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (selector == SEL_W'(k)) raw_pc = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign we     = pc_write | (pc_write_cond & cond);
  assign pc_out = pc_q;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] TRAP = 1'b1;

  logic [0:0]       state_d, state_q;
  logic [WIDTH-1:0] epc_d, epc_q;
  logic [WIDTH-1:0] bad_addr_d, bad_addr_q;
  logic             trap_d, trap_q;
  logic             misaligned;

  assign next_pc    = raw_pc;
  assign misaligned = |next_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    bad_addr_d = bad_addr_q;
    trap_d     = 1'b0;
    case (state_q)
      RUN: begin
        if (we) begin
          if (misaligned) begin
            epc_d      = pc_q;
            bad_addr_d = next_pc;
            state_d    = TRAP;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      TRAP: begin
        // Write strobes are deliberately ignored while redirecting.
        pc_d    = TRAP_VECTOR;
        trap_d  = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      bad_addr_q <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      bad_addr_q <= bad_addr_d;
      trap_q     <= trap_d;
    end
  end

  assign epc_out  = epc_q;
  assign bad_addr = bad_addr_q;
  assign trap     = trap_q;
  assign busy     = (state_q == TRAP);
`else
  // Without the alignment check the low two target bits are simply cleared.
  assign next_pc = raw_pc & ~WIDTH'(3);

  always_comb begin
    pc_d = pc_q;
    if (we) pc_d = next_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign epc_out  = '0;
  assign bad_addr = '0;
  assign trap     = 1'b0;
  assign busy     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_select_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_select_reg
// Purpose  : Self-checking bench for pc_select_reg (4-source and 6-source
//            instances); trap scenarios run when PC_ALIGN_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_select_reg;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   selector;
  logic [127:0] data_in;
  logic         pc_write, pc_write_cond, cond;
  logic [31:0]  pc_out, next_pc, epc_out, bad_addr;
  logic         trap, busy;

  logic [2:0]   sel6;
  logic [191:0] data6;
  logic [31:0]  pc_out6, next_pc6, epc_out6, bad_addr6;
  logic         trap6, busy6;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pc_select_reg #(.WIDTH(32), .NUM_SRC(4)) dut (
    .clk(clk), .reset(reset), .selector(selector), .data_in(data_in),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond(cond),
    .pc_out(pc_out), .next_pc(next_pc), .epc_out(epc_out),
    .bad_addr(bad_addr), .trap(trap), .busy(busy)
  );

  pc_select_reg #(.WIDTH(32), .NUM_SRC(6), .SEL_W(3)) dut6 (
    .clk(clk), .reset(reset), .selector(sel6), .data_in(data6),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond(cond),
    .pc_out(pc_out6), .next_pc(next_pc6), .epc_out(epc_out6),
    .bad_addr(bad_addr6), .trap(trap6), .busy(busy6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name);
    logic [31:0] exp;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, pc_out=%h", name, pc_out);
    end else begin
      exp = exp_q.pop_front();
      if (pc_out !== exp) $display("FAIL %s: pc_out=%h expected=%h", name, pc_out, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; pc_write = 1'b1; pc_write_cond = 1'b0; cond = 1'b0;
    selector = 2'd1;
    for (int k = 0; k < 4; k++) data_in[k*32 +: 32] = 32'h100 * (k + 1);
    for (int k = 0; k < 6; k++) data6[k*32 +: 32] = 32'h1000 * (k + 1);
    sel6 = 3'd0;
    step(); step();
    total_cnt++;
    if ({pc_out, epc_out, bad_addr, trap, busy} !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0})
      $display("FAIL reset: pc=%h epc=%h bad=%h trap=%b busy=%b expected all zero",
               pc_out, epc_out, bad_addr, trap, busy);
    else pass_cnt++;
    reset = 1'b1; pc_write = 1'b0;
  endtask

  task automatic test_source_sweep();
    logic [31:0] exp;
    pc_write = 1'b1;
    for (int s = 0; s < 4; s++) begin
      selector = 2'(s);
      exp = 32'h100 * (s + 1);
      exp_q.push_back(exp);
      #1;
      total_cnt++;
      if (next_pc !== exp) $display("FAIL sweep_next_pc%0d: next_pc=%h expected=%h", s, next_pc, exp);
      else pass_cnt++;
      step();
      pop_check($sformatf("sweep_pc%0d", s));
    end
    pc_write = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp;
    pc_write = 1'b1;
    for (int s = 5; s < 8; s++) begin
      sel6 = 3'(s);
      exp = (s < 6) ? 32'h1000 * (s + 1) : 32'h1000;
      step();
      total_cnt++;
      if (pc_out6 !== exp) $display("FAIL sel6_%0d: pc_out=%h expected=%h", s, pc_out6, exp);
      else pass_cnt++;
    end
    pc_write = 1'b0;
  endtask

  task automatic test_cond_branch();
    selector = 2'd0;
    data_in[0 +: 32] = 32'h40;
    pc_write = 1'b0; pc_write_cond = 1'b1; cond = 1'b0;
    exp_q.push_back(32'h400);
    step();
    pop_check("cond_not_taken");
    cond = 1'b1;
    exp_q.push_back(32'h40);
    step();
    pop_check("cond_taken");
    pc_write_cond = 1'b0; cond = 1'b0;
    exp_q.push_back(32'h40);
    step();
    pop_check("idle_hold");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int k = 0; k < 4; k++) data_in[k*32 +: 32] = 32'h2000 + 32'h10 * k;
    // Both strobes high with cond=1 is still one load.
    pc_write = 1'b1; pc_write_cond = 1'b1; cond = 1'b1;
    for (int i = 0; i < 6; i++) begin
      selector = 2'($urandom_range(0, 3));
      exp = 32'h2000 + 32'h10 * selector;
      exp_q.push_back(exp);
      step();
      pop_check($sformatf("b2b_%0d", i));
    end
    pc_write = 1'b0; pc_write_cond = 1'b0; cond = 1'b0;
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic test_trap();
    selector = 2'd0;
    data_in[0 +: 32] = 32'h20;
    pc_write = 1'b1;
    step();
    data_in[0 +: 32] = 32'h42;
    step();
    total_cnt++;
    if ({busy, trap, pc_out, epc_out, bad_addr} !== {1'b1, 1'b0, 32'h20, 32'h20, 32'h42})
      $display("FAIL trap_enter: busy=%b trap=%b pc=%h epc=%h bad=%h expected 1 0 20 20 42",
               busy, trap, pc_out, epc_out, bad_addr);
    else pass_cnt++;
    data_in[0 +: 32] = 32'h80;
    step();
    total_cnt++;
    if ({busy, trap, pc_out, epc_out, bad_addr} !== {1'b0, 1'b1, 32'hFC, 32'h20, 32'h42})
      $display("FAIL trap_vector: busy=%b trap=%b pc=%h epc=%h bad=%h expected 0 1 fc 20 42",
               busy, trap, pc_out, epc_out, bad_addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({busy, trap, pc_out} !== {1'b0, 1'b0, 32'h80})
      $display("FAIL trap_cycle_load: busy=%b trap=%b pc=%h expected 0 0 80", busy, trap, pc_out);
    else pass_cnt++;
    pc_write = 1'b0;
  endtask

  task automatic test_reset_mid_trap();
    data_in[0 +: 32] = 32'h42;
    pc_write = 1'b1;
    step();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL midtrap_busy: busy=%b expected 1", busy);
    else pass_cnt++;
    reset = 1'b0;
    step();
    reset = 1'b1; pc_write = 1'b0;
    total_cnt++;
    if ({pc_out, busy, trap} !== {32'h0, 1'b0, 1'b0})
      $display("FAIL midtrap_reset: pc=%h busy=%b trap=%b expected 0 0 0", pc_out, busy, trap);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({pc_out, trap} !== {32'h0, 1'b0})
      $display("FAIL midtrap_no_pulse: pc=%h trap=%b expected 0 0", pc_out, trap);
    else pass_cnt++;
  endtask
`else
  task automatic test_mask();
    selector = 2'd0;
    data_in[0 +: 32] = 32'h43;
    pc_write = 1'b1;
    #1;
    total_cnt++;
    if (next_pc !== 32'h40) $display("FAIL mask_next_pc: next_pc=%h expected=40", next_pc);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({pc_out, trap, busy, epc_out, bad_addr} !== {32'h40, 1'b0, 1'b0, 32'h0, 32'h0})
      $display("FAIL mask_load: pc=%h trap=%b busy=%b epc=%h bad=%h expected 40 0 0 0 0",
               pc_out, trap, busy, epc_out, bad_addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (trap !== 1'b0) $display("FAIL mask_no_trap: trap=%b expected 0", trap);
    else pass_cnt++;
    pc_write = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_source_sweep();
    test_out_of_range();
    test_cond_branch();
    test_back_to_back();
`ifdef PC_ALIGN_CHECK_EN
    test_trap();
    test_reset_mid_trap();
`else
    test_mask();
`endif
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
